// File: rtl/ep_wire_alu_bank.sv
// ep_wire_alu_bank: snapshotted, sequenced shared add/sub bank between FrontPanel wire endpoints.
// Define EP_WIRE_ALU_BANK_SATURATE_EN to clamp ADD/ACC/SUB results instead of wrapping.
module ep_wire_alu_bank #(
    parameter int N_CH   = 4,
    parameter int WIDTH  = 16,
    parameter int DROP_W = 8
) (
    input  logic                    ti_clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    clear,
    input  logic [2*N_CH-1:0]       mode,
    input  logic [N_CH*WIDTH-1:0]   op_a,
    input  logic [N_CH*WIDTH-1:0]   op_b,
    output logic [N_CH*WIDTH-1:0]   result,
    output logic [N_CH-1:0]         carry,
    output logic                    busy,
    output logic                    done,
    output logic [DROP_W-1:0]       drop_count
);
    localparam int IW = N_CH > 1 ? $clog2(N_CH) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [IW-1:0] idx;
    logic [2*N_CH-1:0] sh_mode;
    logic [N_CH*WIDTH-1:0] sh_a, sh_b;
    logic [1:0] m;
    logic [WIDTH-1:0] a, b, prev, res;
    logic [WIDTH:0] s;
    logic last, c;
    assign m    = sh_mode[2*idx +: 2];
    assign a    = sh_a[idx*WIDTH +: WIDTH];
    assign b    = sh_b[idx*WIDTH +: WIDTH];
    assign prev = result[idx*WIDTH +: WIDTH];
    assign last = idx == IW'(N_CH-1);
    assign busy = state != IDLE;
    assign done = state == DONE;
    // WIDTH+1 bit datapath: bit WIDTH is the carry for add and the borrow for subtract
    always_comb begin
        s = m == 2'b01 ? {1'b0, a} + {1'b0, b} :
            m == 2'b10 ? {1'b0, a} - {1'b0, b} :
            m == 2'b11 ? {1'b0, prev} + {1'b0, a} : {1'b0, a};
        c = (m != 2'b00) & s[WIDTH];
`ifdef EP_WIRE_ALU_BANK_SATURATE_EN
        res = c ? (m == 2'b10 ? '0 : '1) : s[WIDTH-1:0];
`else
        res = s[WIDTH-1:0];
`endif
    end
    always_comb begin
        state_nx = clear ? IDLE :
                   state == IDLE ? (start ? RUN : IDLE) :
                   state == RUN ? (last ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge ti_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            sh_mode    <= '0;
            sh_a       <= '0;
            sh_b       <= '0;
            result     <= '0;
            carry      <= '0;
            drop_count <= '0;
        end else begin
            state <= state_nx;
            if (clear) begin
                idx        <= '0;
                result     <= '0;
                carry      <= '0;
                drop_count <= '0;
            end else begin
                if (state == IDLE && start) begin
                    sh_mode <= mode;
                    sh_a    <= op_a;
                    sh_b    <= op_b;
                    idx     <= '0;
                end
                if (start && busy && ~&drop_count)
                    drop_count <= drop_count + 1'b1;
                if (state == RUN) begin
                    result[idx*WIDTH +: WIDTH] <= res;
                    carry[idx]                 <= c;
                    idx                        <= last ? '0 : idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ep_wire_alu_bank.sv
// tb_ep_wire_alu_bank: randomized and directed bench for ep_wire_alu_bank against an arithmetic model.
module tb_ep_wire_alu_bank;
    localparam int N = 4;
    localparam int W = 16;
    localparam int MAX = 65535;
`ifdef EP_WIRE_ALU_BANK_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    logic ti_clk = 1'b0, rst_n = 1'b0, start = 1'b0, clear = 1'b0;
    logic [2*N-1:0] mode = '0;
    logic [N*W-1:0] op_a = '0, op_b = '0;
    logic [N*W-1:0] result;
    logic [N-1:0] carry;
    logic busy, done;
    logic [7:0] drop_count;
    int checks = 0, errors = 0;
    int exp_r [N];
    bit exp_c [N];

    always #5 ti_clk = ~ti_clk;

    ep_wire_alu_bank #(.N_CH(N), .WIDTH(W), .DROP_W(8)) dut (
        .ti_clk(ti_clk), .rst_n(rst_n), .start(start), .clear(clear),
        .mode(mode), .op_a(op_a), .op_b(op_b), .result(result), .carry(carry),
        .busy(busy), .done(done), .drop_count(drop_count)
    );

    task automatic tick();
        @(posedge ti_clk);
        #1;
    endtask

    function automatic void model_zero();
        for (int k = 0; k < N; k++) begin
            exp_r[k] = 0;
            exp_c[k] = 1'b0;
        end
    endfunction

    // Plain integer arithmetic per channel; ACC builds on the model's own previous result
    function automatic void model(input logic [2*N-1:0] md, input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        for (int k = 0; k < N; k++) begin
            int av, bv, op, t;
            bit c;
            av = int'(a[k*W +: W]);
            bv = int'(b[k*W +: W]);
            op = int'(md[2*k +: 2]);
            t = op == 1 ? av + bv : op == 2 ? av - bv : op == 3 ? exp_r[k] + av : av;
            c = op == 0 ? 1'b0 : op == 2 ? (t < 0) : (t > MAX);
            exp_r[k] = (SAT && c) ? (op == 2 ? 0 : MAX) : (t < 0 ? t + MAX + 1 : t % (MAX + 1));
            exp_c[k] = c;
        end
    endfunction

    function automatic logic [N*W-1:0] rvec();
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = W'(exp_r[k]);
        return v;
    endfunction

    function automatic logic [N-1:0] cvec();
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) v[k] = exp_c[k];
        return v;
    endfunction

    task automatic start_pass(input logic [2*N-1:0] md, input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        mode = md;
        op_a = a;
        op_b = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        model(md, a, b);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_zero();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
        checks++; if (carry !== '0) begin errors++; $display("FAIL reset_carry got %b exp 0", carry); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b exp 00", busy, done); end
        checks++; if (drop_count !== '0) begin errors++; $display("FAIL reset_drop got %0d exp 0", drop_count); end
        rst_n = 1'b1;
        tick();
        model_zero();
    endtask

    task automatic test_add();
        logic [N*W-1:0] old;
        old = rvec();
        start_pass(8'b01_01_01_01, {16'hFFFF, 16'd3, 16'd2, 16'd1}, {16'd1, 16'd3, 16'd2, 16'd1});
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL add_busy_rise got %b exp 1", busy); end
        for (int j = 1; j <= 5; j++) begin
            tick();
            checks++; if (busy !== (j <= 4) || done !== (j == 4)) begin errors++; $display("FAIL add_timing_e%0d got busy=%b done=%b exp busy=%b done=%b", j, busy, done, j <= 4, j == 4); end
            if (j <= 4) begin
                checks++; if (result[(j-1)*W +: W] !== W'(exp_r[j-1])) begin errors++; $display("FAIL add_ch%0d_visible got %h exp %h", j-1, result[(j-1)*W +: W], W'(exp_r[j-1])); end
                if (j < 4) begin
                    checks++; if (result[N*W-1 -: W] !== old[N*W-1 -: W]) begin errors++; $display("FAIL add_ch3_early got %h exp %h", result[N*W-1 -: W], old[N*W-1 -: W]); end
                end
            end
        end
        checks++; if (result[3*W-1:0] !== {16'd6, 16'd4, 16'd2}) begin errors++; $display("FAIL add_ch012 got %h exp 000600040002", result[3*W-1:0]); end
        checks++; if (result[4*W-1 -: W] !== (SAT ? 16'hFFFF : 16'h0000)) begin errors++; $display("FAIL add_ch3 got %h", result[4*W-1 -: W]); end
        checks++; if (carry !== 4'b1000) begin errors++; $display("FAIL add_carry got %b exp 1000", carry); end
    endtask

    task automatic test_sub();
        int n;
        start_pass(8'b00_00_00_10, {16'd0, 16'd0, 16'h1234, 16'd5}, {16'd9, 16'd9, 16'd9, 16'd7});
        wait_done(n);
        checks++; if (n !== 4) begin errors++; $display("FAIL sub_latency got %0d exp 4", n); end
        checks++; if (result[W-1:0] !== (SAT ? 16'h0000 : 16'hFFFE)) begin errors++; $display("FAIL sub_ch0 got %h", result[W-1:0]); end
        checks++; if (result[2*W-1 -: W] !== 16'h1234 || carry[1:0] !== 2'b01) begin errors++; $display("FAIL sub_ch1_carry got %h/%b exp 1234/01", result[2*W-1 -: W], carry[1:0]); end
        checks++; if (result !== rvec() || carry !== cvec()) begin errors++; $display("FAIL sub_model got %h/%b exp %h/%b", result, carry, rvec(), cvec()); end
        tick();
    endtask

    task automatic test_acc();
        logic [W-1:0] exp_v [3];
        int n;
        exp_v[0] = 16'h7000;
        exp_v[1] = 16'hE000;
        exp_v[2] = SAT ? 16'hFFFF : 16'h5000;
        do_clear();
        for (int p = 0; p < 3; p++) begin
            start_pass(8'b00_11_00_00, {16'h0, 16'h7000, 16'h0, 16'h0}, {N*W{1'b1}});
            wait_done(n);
            tick();
            checks++; if (result[3*W-1 -: W] !== exp_v[p] || carry[2] !== (p == 2)) begin errors++; $display("FAIL acc_pass%0d got %h/%b exp %h/%b", p, result[3*W-1 -: W], carry[2], exp_v[p], p == 2); end
            checks++; if (result !== rvec() || carry !== cvec()) begin errors++; $display("FAIL acc_model%0d got %h exp %h", p, result, rvec()); end
        end
    endtask

    task automatic test_random();
        int n;
        for (int i = 0; i < 24; i++) begin
            start_pass(8'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
            wait_done(n);
            checks++; if (n !== 4) begin errors++; $display("FAIL rand%0d_latency got %0d exp 4", i, n); end
            checks++; if (result !== rvec() || carry !== cvec()) begin errors++; $display("FAIL rand%0d got %h/%b exp %h/%b", i, result, carry, rvec(), cvec()); end
            tick();
        end
    endtask

    task automatic test_snapshot_drop();
        int nd;
        nd = 0;
        do_clear();
        start_pass(8'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
        op_a = ~op_a;
        op_b = ~op_b;
        mode = ~mode;
        start = 1'b1;
        tick(); nd += int'(done);
        start = 1'b0;
        tick(); nd += int'(done);
        start = 1'b1;
        tick(); nd += int'(done);
        start = 1'b0;
        for (int j = 0; j < 6; j++) begin
            tick(); nd += int'(done);
        end
        checks++; if (nd !== 1) begin errors++; $display("FAIL snap_done_pulses got %0d exp 1", nd); end
        checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL snap_drop got %0d exp 2", drop_count); end
        checks++; if (result !== rvec() || carry !== cvec()) begin errors++; $display("FAIL snap_result got %h exp %h", result, rvec()); end
    endtask

    task automatic test_clear_mid();
        logic [N*W-1:0] a;
        int nd;
        nd = 0;
        do_clear();
        a = {$urandom, $urandom};
        a[0] = 1'b1;
        start_pass(8'($urandom) & 8'hFC, a, {$urandom, $urandom});
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (drop_count !== 8'd1 || result[W-1:0] !== a[W-1:0]) begin errors++; $display("FAIL clrmid_pre got %0d/%h exp 1/%h", drop_count, result[W-1:0], a[W-1:0]); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_zero();
        checks++; if (result !== '0 || carry !== '0) begin errors++; $display("FAIL clrmid_data got %h/%b exp 0", result, carry); end
        checks++; if (busy !== 1'b0 || drop_count !== '0) begin errors++; $display("FAIL clrmid_status got %b/%0d exp 0/0", busy, drop_count); end
        for (int j = 0; j < 6; j++) begin
            nd += int'(done);
            tick();
        end
        checks++; if (nd !== 0 || result !== '0) begin errors++; $display("FAIL clrmid_no_done got %0d/%h exp 0/0", nd, result); end
    endtask

    task automatic test_clear_start();
        start = 1'b1;
        clear = 1'b1;
        tick();
        start = 1'b0;
        clear = 1'b0;
        checks++; if (busy !== 1'b0 || drop_count !== '0) begin errors++; $display("FAIL clrstart got %b/%0d exp 0/0", busy, drop_count); end
        tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL clrstart_idle got %b%b exp 00", busy, done); end
    endtask

    task automatic test_async_reset();
        logic [N*W-1:0] a;
        a = {$urandom, $urandom};
        a[W] = 1'b1;
        a[0] = 1'b1;
        start_pass(8'b00_00_00_00, a, '0);
        tick();
        tick();
        checks++; if (result[2*W-1:0] !== a[2*W-1:0] || busy !== 1'b1) begin errors++; $display("FAIL arst_pre got %h/%b exp %h/1", result[2*W-1:0], busy, a[2*W-1:0]); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (result !== '0 || carry !== '0 || busy !== 1'b0 || done !== 1'b0 || drop_count !== '0) begin errors++; $display("FAIL arst_immediate got %h/%b/%b/%b/%0d exp all 0", result, carry, busy, done, drop_count); end
        #3;
        rst_n = 1'b1;
        model_zero();
        tick();
        checks++; if (busy !== 1'b0 || result !== '0) begin errors++; $display("FAIL arst_after got %b/%h exp 0/0", busy, result); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_acc();
        test_random();
        test_snapshot_drop();
        test_clear_mid();
        test_clear_start();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
